// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
// State encoding, baud divisor calculation and legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and wraps, tick on DIV-1.
// A synchronous restart forces the count back to zero.
module uart_baud_gen #(
  parameter int DIV = 16,
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  output logic         tick,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  assign tick = (count == LAST);

  // Count bit-period clocks; restart or wrap returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one character per valid/ready handshake.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [W-1:0] PRE   = W'(DIV - 2);
  localparam logic [2:0]   DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]   SLAST = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_db
    $error("uart_tx_frame: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_sb
    $error("uart_tx_frame: STOP_BITS must be 1..2");
  end

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_cnt;
  logic                 accept;
  logic                 restart;
  logic                 tick;
  logic [W-1:0]         count;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign accept  = tx_valid && tx_ready;
  assign restart = accept || (state == IDLE);
  assign busy    = (state != IDLE);

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick),
    .count  (count)
  );

  // Frame sequencer; tx and tx_ready are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (accept) begin
      state    <= START;
      shift    <= tx_data;
      bit_cnt  <= '0;
      tx       <= 1'b0;
      tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == DLAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt == SLAST) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else if (bit_cnt == SLAST && count == PRE) begin
            tx_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised scoreboard bench for uart_tx_frame.
// Small bit period keeps frames short; parity follows UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DB     = 7;
  localparam int SB     = 2;
  localparam int ODD    = 1;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DB + P + SB;
  localparam int F     = NBITS * DIV;

  typedef struct {
    logic [DB-1:0] d;
    longint        acc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          busy;

  exp_t   q[$];
  int     checks = 0;
  int     fails = 0;
  int     unexpected = 0;
  int     idle_err = 0;
  longint cyc = 0;

  uart_tx_frame #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(ODD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line level for frame bit k: start, data LSB first, parity, stops.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (P == 1 && k == DB + 1) return (^d) ^ (ODD != 0);
    return 1'b1;
  endfunction

  logic in_frame = 1'b0;
  logic spurious = 1'b0;
  int   idx = 0;
  int   tx_err = 0;
  int   hs_err = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (tx === 1'b0) begin
          if (q.size() == 0) begin
            unexpected++;
            spurious = 1'b1;
            cur.d = '1;
            cur.acc = cyc;
          end else begin
            cur = q.pop_front();
            spurious = 1'b0;
            check($sformatf("start_cycle_%02h", cur.d), cyc, cur.acc);
          end
          in_frame = 1'b1;
          idx = 0;
          tx_err = 0;
          hs_err = 0;
        end else if (busy !== 1'b0) begin
          idle_err++;
        end
      end
      if (in_frame) begin
        if (tx !== frame_bit(cur.d, idx / DIV)) tx_err++;
        if (busy !== 1'b1) hs_err++;
        if (tx_ready !== (idx == F - 1)) hs_err++;
        idx++;
        if (idx == F) begin
          in_frame = 1'b0;
          if (!spurious) begin
            check($sformatf("frame_tx_%02h", cur.d), tx_err, 0);
            check($sformatf("frame_hs_%02h", cur.d), hs_err, 0);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [DB-1:0] d);
    exp_t e;
    int   n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    e.d   = d;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = DB'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3 * F) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    check("idle_tx", tx, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    #12;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", tx_ready, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);

    send(7'h41);
    wait_idle();
    check("ready_single_shot", tx_ready, 1);
    repeat (5) @(negedge clk);

    send(7'h0D);
    send(7'h0A);
    wait_idle();

    send(7'h55);
    repeat (3 * DIV) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = '1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    repeat (2 * DIV) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(DB'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    wait_idle();

    send(7'h33);
    repeat (3 * DIV) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_ready", tx_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", tx_ready, 1);
    send(DB'(8'hA5));
    wait_idle();

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("unexpected_frames", unexpected, 0);
    check("idle_busy", idle_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one character per valid/ready handshake into a standard asynchronous frame: start bit, 5–8 data bits LSB-first, optional parity, and 1 or 2 stop bits. It is the next-generation replacement for the fixed 9600-baud, fixed-string transmitter on the board's UART TX pin. Character sequencing, such as strings and button triggers, moves upstream into the producer, so this block only accepts characters and frames them.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- BAUD, 9600, line rate; bit period DIV = CLK_HZ/BAUD (integer division, 5208 at defaults)
- DATA_BITS, 8, data bits per frame, legal 5..8
- STOP_BITS, 1, stop bits per frame, legal 1..2
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd; ignored otherwise
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- tx_data  input  DATA_BITS  character to send; sampled only at accept
- tx_valid  input  1  producer has a character
- tx_ready  output  1  block can accept; accept = tx_valid && tx_ready at a rising edge
- tx  output  1  serial line, idle high; registered
- busy  output  1  frame in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP, held in a registered FSM.
- IDLE: tx=1. On accept, capture tx_data into the shift register, clear the baud counter and the bit counter, and go to START.
- START: tx=0 for DIV cycles, then go to DATA.
- DATA: send shift[0] for DIV cycles per bit, shift right, and count DATA_BITS bits. Then go to PARITY if compiled in, otherwise STOP.
- PARITY: tx = XOR of the captured data bits, inverted when PARITY_ODD=1. Lasts DIV cycles.
- STOP: tx=1 for STOP_BITS*DIV cycles, then go to IDLE. If an accept occurs in the final cycle of the stop period, go directly to START instead.
- Baud counter: width $clog2(DIV). It counts 0..DIV-1 and wraps; the bit advances on the count DIV-1. The counter is not free-running and restarts at every accept.
- tx_ready: registered. It is set in IDLE and in the final clock of the last stop bit, and cleared on the edge after an accept.
- busy = (state != IDLE).
- tx_valid while tx_ready=0: ignored. tx_data may change freely after accept.
- Reset mid-frame: tx returns to 1 immediately and asynchronously. The frame is abandoned with no resumption and no partial character held.
- Elaboration error when DIV < 2, DATA_BITS is outside 5..8, or STOP_BITS is outside 1..2.

## Timing
- Reset values: tx=1, tx_ready=0, busy=0, state=IDLE, all counters 0.
- tx_ready rises on the first rising edge after rst_n deasserts.
- Accept at edge E0: tx=0, busy=1 and tx_ready=0 are all visible after E0, so the start bit begins one edge after the handshake.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) * DIV cycles, where P is 1 with parity and 0 without. At defaults F = 52080.
- Back-to-back: with tx_valid held high, the next start bit begins exactly F cycles after the previous one, with no idle gap.
- Single-shot: after the last stop bit, tx stays 1 and busy=0 until the next accept.

## Configuration
- UART_TX_PARITY_EN
  - Defined: the PARITY state is present, P=1, and PARITY_ODD selects the sense.
  - Undefined: the PARITY state and its logic are removed, P=0, and PARITY_ODD has no effect.

## Structure
- Package uart_pkg holds:
  - the state enum typedef (uart_tx_state_t);
  - a function computing DIV from CLK_HZ/BAUD;
  - legal-range constants for DATA_BITS and STOP_BITS.
- One sub-module, uart_baud_gen, holds the DIV-parameter counter. It has sync-restart and tick outputs and is reused by the planned receiver.

## Test plan
- Defaults, send 0x55:
  - tx low for 5208 cycles, then data 1,0,1,0,1,0,1,0 at 5208 cycles each, then high.
  - busy falls 52080 cycles after accept.
  - tx_ready is re-asserted in the final stop-bit cycle.
- Back-to-back 0x0D then 0x0A with tx_valid held:
  - second start edge exactly 52080 cycles after the first;
  - tx never low outside the start and data bits.
- UART_TX_PARITY_EN, send 0x07:
  - PARITY_ODD=0: parity bit 1.
  - PARITY_ODD=1: parity bit 0.
  - F=57288 in both cases.
- CLK_HZ=16, BAUD=1 (DIV=16), DATA_BITS=7, STOP_BITS=2, send 0x41:
  - 7 data bits 1,0,0,0,0,0,1;
  - stop high for 32 cycles;
  - F=160.
- Pulse tx_valid with 0xFF mid-frame while tx_ready=0: ignored; the current frame is unchanged and no second frame is sent.
- Assert rst_n low during the DATA state:
  - tx=1 and busy=0 asynchronously;
  - after release, tx_ready=1 on the next edge and a fresh 0xA5 frame is sent correctly.
